load_sequencer: RTL and testbench



---
 rtl/load_sequencer.sv | 163 ++++++++++++++++
 tb/tb_load_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_sequencer.sv
// -----------------------------------------------------------------------------
// load_sequencer
//
// Upstream sequencer for the autoencoder's 16-entry register bank. A burst of
// N_WORDS words arrives on a valid/ready stream. Each accepted word is
// registered onto a broadcast data bus together with a 4-bit slot select and a
// single write strobe. Those three signals feed the 1-to-16 enable demux, which
// turns them into one write-enable per register slot. The end of a burst is
// reported with a one-cycle done pulse so the layer controller can start
// compute.
//
// Parameters
//   DATA_WIDTH  width of each loaded word (fixed-point activation/weight)
//   N_WORDS     words per burst, 1..16; slots 0..N_WORDS-1 are written
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin a burst; only looked at while idle
//   abort     in   synchronous cancel; back to idle with no done pulse
//   in_valid  in   upstream word valid
//   in_data   in   upstream word
//   in_ready  out  combinational; high while loading and not aborting
//   data_out  out  registered word, broadcast to all slots
//   sel       out  registered slot index, to the demux select
//   en        out  registered write strobe, to the demux enable
//   count     out  words accepted in the current burst (0..N_WORDS)
//   busy      out  high while loading or finishing a burst
//   done      out  registered one-cycle pulse at the end of a burst
// -----------------------------------------------------------------------------
module load_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int N_WORDS    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [3:0]            sel,
   output logic                  en,
   output logic [4:0]            count,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   // Index of the final word of a burst and the saturation value of count.
   localparam logic [4:0] LAST_IDX  = 5'(N_WORDS - 1);
   localparam logic [4:0] COUNT_MAX = 5'(N_WORDS);

   state_t                state_q,    state_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic [3:0]            sel_q,      sel_d;
   logic                  en_q,       en_d;
   logic [4:0]            count_q,    count_d;
   logic                  done_q,     done_d;

   logic                  ready;
   logic                  accept;

   // abort takes effect in the same cycle it is seen, so a word offered
   // alongside an abort is never accepted.
   assign ready = (state_q == LOAD) && !abort;

   // The count guard keeps count from wrapping and keeps sel below N_WORDS
   // even if the state and count ever disagree.
   assign accept = in_valid && ready && (count_q < COUNT_MAX);

   // --------------------------------------------------------------------------
   // Next-state and next-output logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch. en and done default low,
      // which is what makes them single-cycle strobes.
      state_d    = state_q;
      data_out_d = data_out_q;
      sel_d      = sel_q;
      en_d       = 1'b0;
      count_d    = count_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            // start together with abort leaves the sequencer idle; count
            // keeps the last burst's value for debug until a real start.
            if (start && !abort) begin
               state_d = LOAD;
               count_d = '0;
            end
         end

         LOAD: begin
            if (abort) begin
               state_d = IDLE;
            end else if (accept) begin
               data_out_d = in_data;
               sel_d      = count_q[3:0];
               en_d       = 1'b1;
               count_d    = count_q + 5'd1;
               if (count_q == LAST_IDX) begin
                  state_d = DONE;
               end
            end
         end

         DONE: begin
            // One cycle here lets the final write strobe land before done
            // rises; an abort in this cycle suppresses the done pulse.
            state_d = IDLE;
            done_d  = !abort;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State and output registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         data_out_q <= '0;
         sel_q      <= '0;
         en_q       <= 1'b0;
         count_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values computed above, independent of statement order.
         state_q    <= state_d;
         data_out_q <= data_out_d;
         sel_q      <= sel_d;
         en_q       <= en_d;
         count_q    <= count_d;
         done_q     <= done_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign in_ready = ready;
   assign data_out = data_out_q;
   assign sel      = sel_q;
   assign en       = en_q;
   assign count    = count_q;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;

endmodule

// File: tb/tb_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_load_sequencer
//
// Directed bench for load_sequencer. Two instances run side by side: dut_a with
// N_WORDS=16 and dut_b with N_WORDS=4. Every word the bench expects to be
// accepted is pushed to a per-instance queue tagged with the cycle it was
// offered. A negedge monitor expects en exactly one cycle later, pops the
// entry and compares sel/data_out. It also checks that en is low and sel/data
// hold in every other cycle.
// -----------------------------------------------------------------------------
module tb_load_sequencer;

   typedef struct {
      int          cyc;
      logic [3:0]  sel;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   logic        a_start, a_abort, a_valid;
   logic [15:0] a_in;
   logic        a_ready, a_en, a_busy, a_done;
   logic [15:0] a_data;
   logic [3:0]  a_sel;
   logic [4:0]  a_count;

   logic        b_start, b_abort, b_valid;
   logic [15:0] b_in;
   logic        b_ready, b_en, b_busy, b_done;
   logic [15:0] b_data;
   logic [3:0]  b_sel;
   logic [4:0]  b_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int a_idx = 0;
   int b_idx = 0;

   exp_t        qa[$];
   exp_t        qb[$];
   logic [3:0]  a_hold_sel,  b_hold_sel;
   logic [15:0] a_hold_data, b_hold_data;

   load_sequencer #(.DATA_WIDTH(16), .N_WORDS(16)) dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (a_start),
      .abort    (a_abort),
      .in_valid (a_valid),
      .in_data  (a_in),
      .in_ready (a_ready),
      .data_out (a_data),
      .sel      (a_sel),
      .en       (a_en),
      .count    (a_count),
      .busy     (a_busy),
      .done     (a_done)
   );

   load_sequencer #(.DATA_WIDTH(16), .N_WORDS(4)) dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (b_start),
      .abort    (b_abort),
      .in_valid (b_valid),
      .in_data  (b_in),
      .in_ready (b_ready),
      .data_out (b_data),
      .sel      (b_sel),
      .en       (b_en),
      .count    (b_count),
      .busy     (b_busy),
      .done     (b_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns one time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------- monitors
   task automatic mon_a();
      exp_t e;
      logic exp_en;
      if (!rst_n) begin
         a_hold_sel  = '0;
         a_hold_data = '0;
      end
      while (qa.size() > 0 && qa[0].cyc + 1 < cyc) begin
         check("a_en_missing_cycle", 32'(cyc), 32'(qa[0].cyc + 1));
         void'(qa.pop_front());
      end
      exp_en = (qa.size() > 0) && (qa[0].cyc + 1 == cyc);
      check("a_en", 32'(a_en), 32'(exp_en));
      if (exp_en) begin
         e           = qa.pop_front();
         a_hold_sel  = e.sel;
         a_hold_data = e.data;
      end
      check("a_sel", 32'(a_sel), 32'(a_hold_sel));
      check("a_data", 32'(a_data), 32'(a_hold_data));
   endtask

   task automatic mon_b();
      exp_t e;
      logic exp_en;
      if (!rst_n) begin
         b_hold_sel  = '0;
         b_hold_data = '0;
      end
      while (qb.size() > 0 && qb[0].cyc + 1 < cyc) begin
         check("b_en_missing_cycle", 32'(cyc), 32'(qb[0].cyc + 1));
         void'(qb.pop_front());
      end
      exp_en = (qb.size() > 0) && (qb[0].cyc + 1 == cyc);
      check("b_en", 32'(b_en), 32'(exp_en));
      if (exp_en) begin
         e           = qb.pop_front();
         b_hold_sel  = e.sel;
         b_hold_data = e.data;
      end
      check("b_sel", 32'(b_sel), 32'(b_hold_sel));
      check("b_data", 32'(b_data), 32'(b_hold_data));
   endtask

   initial begin
      forever begin
         @(negedge clk);
         mon_a();
         mon_b();
      end
   end

   // ---------------------------------------------------------------- drivers
   // Offer one word that the bench expects to be accepted.
   task automatic a_word(input logic [15:0] d);
      a_valid = 1'b1;
      a_in    = d;
      qa.push_back('{cyc: cyc, sel: 4'(a_idx), data: d});
      a_idx++;
      tick();
   endtask

   task automatic b_word(input logic [15:0] d);
      b_valid = 1'b1;
      b_in    = d;
      qb.push_back('{cyc: cyc, sel: 4'(b_idx), data: d});
      b_idx++;
      tick();
   endtask

   task automatic a_start_burst(input string tag);
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      a_idx   = 0;
      check({tag, "_busy_load"},  32'(a_busy),  32'd1);
      check({tag, "_ready_load"}, 32'(a_ready), 32'd1);
      check({tag, "_count_clr"},  32'(a_count), 32'd0);
   endtask

   // Called one cycle after the last handshake: DONE now, done pulse next.
   task automatic a_finish(input string tag);
      a_valid = 1'b0;
      check({tag, "_busy_done"},  32'(a_busy),  32'd1);
      check({tag, "_ready_done"}, 32'(a_ready), 32'd0);
      check({tag, "_done_early"}, 32'(a_done),  32'd0);
      check({tag, "_count"},      32'(a_count), 32'd16);
      tick();
      check({tag, "_done_pulse"}, 32'(a_done),  32'd1);
      check({tag, "_busy_idle"},  32'(a_busy),  32'd0);
      check({tag, "_count_hold"}, 32'(a_count), 32'd16);
      tick();
      check({tag, "_done_single"}, 32'(a_done), 32'd0);
   endtask

   task automatic a_full_burst(input string tag, input logic [15:0] base);
      a_start_burst(tag);
      for (int i = 0; i < 16; i++) a_word(base + 16'(i));
      a_finish(tag);
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      rst_n   = 1'b0;
      a_start = 1'b0; a_abort = 1'b0; a_valid = 1'b0; a_in = '0;
      b_start = 1'b0; b_abort = 1'b0; b_valid = 1'b0; b_in = '0;
      repeat (3) tick();

      // Reset state.
      check("rst_a_data",  32'(a_data),  32'd0);
      check("rst_a_sel",   32'(a_sel),   32'd0);
      check("rst_a_en",    32'(a_en),    32'd0);
      check("rst_a_count", 32'(a_count), 32'd0);
      check("rst_a_busy",  32'(a_busy),  32'd0);
      check("rst_a_done",  32'(a_done),  32'd0);
      check("rst_a_ready", 32'(a_ready), 32'd0);
      check("rst_b_count", 32'(b_count), 32'd0);
      check("rst_b_ready", 32'(b_ready), 32'd0);
      rst_n = 1'b1;
      tick();

      // Back-to-back burst of 16 words 0x0001..0x0010.
      a_full_burst("full", 16'h0001);

      // N_WORDS=4 instance: in_valid stays high past the last word.
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      b_idx   = 0;
      check("b4_busy_load",  32'(b_busy),  32'd1);
      check("b4_ready_load", 32'(b_ready), 32'd1);
      for (int i = 0; i < 4; i++) b_word(16'h1111 * 16'(i + 1));
      b_in = 16'h5555;
      check("b4_busy_done",  32'(b_busy),  32'd1);
      check("b4_ready_done", 32'(b_ready), 32'd0);
      check("b4_count",      32'(b_count), 32'd4);
      check("b4_done_early", 32'(b_done),  32'd0);
      tick();
      check("b4_done_pulse", 32'(b_done),  32'd1);
      check("b4_busy_idle",  32'(b_busy),  32'd0);
      check("b4_count_sat",  32'(b_count), 32'd4);
      tick();
      check("b4_done_single", 32'(b_done), 32'd0);
      check("b4_ready_idle",  32'(b_ready), 32'd0);
      b_valid = 1'b0;
      tick();

      // in_valid toggling 1,0,1,0 then the rest of the burst back-to-back.
      a_start_burst("toggle");
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin
            a_word(16'hA000 + 16'(i));
         end else begin
            a_valid = 1'b0;
            a_in    = 16'hA000 + 16'(i);
            tick();
         end
      end
      check("toggle_count_mid", 32'(a_count), 32'd4);
      for (int i = 0; i < 12; i++) a_word(16'hA100 + 16'(i));
      a_finish("toggle");

      // Abort together with in_valid on the 7th word.
      a_start_burst("abort");
      for (int i = 0; i < 6; i++) a_word(16'hB000 + 16'(i));
      a_in    = 16'hBEEF;
      a_abort = 1'b1;
      #1;
      check("abort_ready_low", 32'(a_ready), 32'd0);
      tick();
      a_abort = 1'b0;
      a_valid = 1'b0;
      check("abort_idle",       32'(a_busy),  32'd0);
      check("abort_count_hold", 32'(a_count), 32'd6);
      check("abort_no_done",    32'(a_done),  32'd0);
      tick();
      check("abort_no_done2",   32'(a_done),  32'd0);
      check("abort_count_hold2", 32'(a_count), 32'd6);

      // Restart from slot 0, then abort in LOAD without a pending word.
      a_start_burst("restart");
      a_word(16'hC000);
      a_valid = 1'b0;
      a_abort = 1'b1;
      tick();
      a_abort = 1'b0;
      check("restart_abort_idle", 32'(a_busy),  32'd0);
      check("restart_count",      32'(a_count), 32'd1);

      // start and abort together while idle: stays idle.
      a_start = 1'b1;
      a_abort = 1'b1;
      tick();
      a_start = 1'b0;
      a_abort = 1'b0;
      check("start_abort_idle",  32'(a_busy),  32'd0);
      check("start_abort_count", 32'(a_count), 32'd1);
      check("start_abort_done",  32'(a_done),  32'd0);
      tick();

      // Asynchronous reset after the 5th word.
      a_start_burst("areset");
      for (int i = 0; i < 5; i++) a_word(16'hD001 + 16'(i));
      a_valid = 1'b0;
      tick();
      a_valid = 1'b1;
      a_in    = 16'hDEAD;
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_data",  32'(a_data),  32'd0);
      check("areset_sel",   32'(a_sel),   32'd0);
      check("areset_en",    32'(a_en),    32'd0);
      check("areset_count", 32'(a_count), 32'd0);
      check("areset_busy",  32'(a_busy),  32'd0);
      check("areset_ready", 32'(a_ready), 32'd0);
      tick();
      check("areset_ready_hold", 32'(a_ready), 32'd0);
      a_valid = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      a_full_burst("post_reset", 16'hE000);

      // start held through LOAD and DONE, then accepted in the done cycle.
      a_start = 1'b1;
      tick();
      a_idx = 0;
      check("hold_busy", 32'(a_busy),  32'd1);
      check("hold_count0", 32'(a_count), 32'd0);
      for (int i = 0; i < 16; i++) begin
         a_word(16'hF000 + 16'(i));
         if (i == 7) check("hold_count_mid", 32'(a_count), 32'd8);
      end
      a_valid = 1'b0;
      check("hold_busy_done",  32'(a_busy),  32'd1);
      check("hold_ready_done", 32'(a_ready), 32'd0);
      check("hold_count16",    32'(a_count), 32'd16);
      tick();
      check("hold_done_pulse", 32'(a_done),  32'd1);
      check("hold_busy_idle",  32'(a_busy),  32'd0);
      check("hold_count_keep", 32'(a_count), 32'd16);
      tick();
      a_start = 1'b0;
      a_idx   = 0;
      check("hold_relaunch_busy",  32'(a_busy),  32'd1);
      check("hold_relaunch_ready", 32'(a_ready), 32'd1);
      check("hold_relaunch_count", 32'(a_count), 32'd0);
      check("hold_relaunch_done",  32'(a_done),  32'd0);

      // Second burst aborted in its DONE cycle: no done pulse.
      for (int i = 0; i < 16; i++) a_word(16'h0100 + 16'(i));
      a_valid = 1'b0;
      a_abort = 1'b1;
      check("done_abort_busy", 32'(a_busy), 32'd1);
      tick();
      a_abort = 1'b0;
      check("done_abort_idle",  32'(a_busy),  32'd0);
      check("done_abort_nodone", 32'(a_done), 32'd0);
      check("done_abort_count", 32'(a_count), 32'd16);
      tick();
      check("done_abort_nodone2", 32'(a_done), 32'd0);

      repeat (3) tick();
      check("a_queue_drained", 32'(qa.size()), 32'd0);
      check("b_queue_drained", 32'(qb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
